// File: rtl/id_stage.sv
// Decode stage: 32x32 register file, operand/immediate decode, registered outputs under valid/ready.
// Optional macro ID_WB_BYPASS_EN: same-cycle writeback data is forwarded to operand reads.
module id_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] InIns,
  input  logic [31:0] InNextPC,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] Ins,
  output logic [31:0] nextPC,
  output logic [31:0] Rdata1,
  output logic [31:0] Rdata2,
  output logic [31:0] Ed32,
  input  logic        WE,
  input  logic [4:0]  Wadr,
  input  logic [31:0] Wdata
);

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        out_valid_q, out_valid_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] rdata2_q, rdata2_d;
  logic [31:0] ed32_q, ed32_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, sh;
  logic [15:0] imm;
  logic        transfer;
  logic [31:0] rd_rs, rd_rt;

  function automatic logic [31:0] rd_port(input logic [4:0] idx);
    logic [31:0] v;
    v = rf_q[idx];
    if (idx == 5'd0) v = '0;
`ifdef ID_WB_BYPASS_EN
    else if (WE && (Wadr == idx)) v = Wdata;
`endif
    return v;
  endfunction

  assign op  = InIns[31:26];
  assign rs  = InIns[25:21];
  assign rt  = InIns[20:16];
  assign sh  = InIns[10:6];
  assign fn  = InIns[5:0];
  assign imm = InIns[15:0];

  assign InReady  = !out_valid_q || OutReady;
  assign transfer = InValid && InReady;
  assign rd_rs    = rd_port(rs);
  assign rd_rt    = rd_port(rt);

  always_comb begin
    rf_d = rf_q;
    if (WE && (Wadr != 5'd0)) rf_d[Wadr] = Wdata;
  end

  // Outputs only move on a transfer; a stall or drain keeps the data untouched.
  always_comb begin
    out_valid_d = out_valid_q;
    ins_d       = ins_q;
    npc_d       = npc_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    ed32_d      = ed32_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      ins_d       = InIns;
      npc_d       = InNextPC;
      if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
        rdata1_d = rd_rt;
        rdata2_d = {27'b0, sh};
      end else if (op == 6'h00 && (fn == 6'h04 || fn == 6'h06 || fn == 6'h07)) begin
        rdata1_d = rd_rt;
        rdata2_d = {27'b0, rd_rs[4:0]};
      end else if (op == 6'h01) begin
        rdata1_d = rd_rs;
        rdata2_d = (rt == 5'd0) ? 32'd1 : 32'd0;
      end else begin
        rdata1_d = rd_rs;
        rdata2_d = rd_rt;
      end
      case (op)
        6'h0C, 6'h0D, 6'h0E: ed32_d = {16'b0, imm};
        6'h0F:               ed32_d = {imm, 16'b0};
        default:             ed32_d = {{16{imm[15]}}, imm};
      endcase
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      out_valid_q <= 1'b0;
      ins_q       <= '0;
      npc_q       <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      ed32_q      <= '0;
    end else begin
      rf_q        <= rf_d;
      out_valid_q <= out_valid_d;
      ins_q       <= ins_d;
      npc_q       <= npc_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      ed32_q      <= ed32_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Ins      = ins_q;
  assign nextPC   = npc_q;
  assign Rdata1   = rdata1_q;
  assign Rdata2   = rdata2_q;
  assign Ed32     = ed32_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus random traffic against a behavioural model.
module tb_id_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        InValid, OutReady, WE;
  logic        InReady, OutValid;
  logic [31:0] InIns, InNextPC, Wdata;
  logic [4:0]  Wadr;
  logic [31:0] Ins, nextPC, Rdata1, Rdata2, Ed32;

  int n_chk  = 0;
  int n_pass = 0;

  id_stage dut (
    .CLK(CLK), .RST(RST),
    .InValid(InValid), .InReady(InReady), .InIns(InIns), .InNextPC(InNextPC),
    .OutValid(OutValid), .OutReady(OutReady),
    .Ins(Ins), .nextPC(nextPC), .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32),
    .WE(WE), .Wadr(Wadr), .Wdata(Wdata)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state
  logic [31:0] m_r [32];
  logic        m_ov;
  logic [31:0] m_ins, m_npc, m_r1, m_r2, m_ed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
    m_ov = 1'b0; m_ins = 0; m_npc = 0; m_r1 = 0; m_r2 = 0; m_ed = 0;
  endtask

  function automatic logic [31:0] m_read(input int idx, input logic we, input int wa, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == idx) return wd;
`endif
    return m_r[idx];
  endfunction

  task automatic check_outputs();
    chk("out_valid", {31'b0, OutValid}, {31'b0, m_ov});
    chk("ins",    Ins,    m_ins);
    chk("nextpc", nextPC, m_npc);
    chk("rdata1", Rdata1, m_r1);
    chk("rdata2", Rdata2, m_r2);
    chk("ed32",   Ed32,   m_ed);
  endtask

  // One clock cycle: drive, check handshake, advance model, then check registered outputs.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] npc,
                     input logic ordy, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    int op, rs, rt, sh, fn, imm;
    logic rdy;
    InValid = iv; InIns = ins; InNextPC = npc; OutReady = ordy; WE = we; Wadr = wa; Wdata = wd;
    #1;
    rdy = !m_ov || ordy;
    chk("in_ready", {31'b0, InReady}, {31'b0, rdy});
    if (iv && rdy) begin
      op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
      sh = int'(ins[10:6]);  fn = int'(ins[5:0]);   imm = int'(ins[15:0]);
      m_ov = 1'b1; m_ins = ins; m_npc = npc;
      if (op == 0 && (fn == 0 || fn == 2 || fn == 3)) begin
        m_r1 = m_read(rt, we, int'(wa), wd); m_r2 = sh;
      end else if (op == 0 && (fn == 4 || fn == 6 || fn == 7)) begin
        m_r1 = m_read(rt, we, int'(wa), wd); m_r2 = m_read(rs, we, int'(wa), wd) % 32;
      end else if (op == 1) begin
        m_r1 = m_read(rs, we, int'(wa), wd); m_r2 = (rt == 0) ? 1 : 0;
      end else begin
        m_r1 = m_read(rs, we, int'(wa), wd); m_r2 = m_read(rt, we, int'(wa), wd);
      end
      if (op >= 12 && op <= 14) m_ed = imm;
      else if (op == 15)        m_ed = imm * 65536;
      else                      m_ed = (imm >= 32768) ? imm - 65536 : imm;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (we && wa != 0) m_r[wa] = wd;
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h01, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h04};
  logic [5:0] fns [8]  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21};

  initial begin
    logic [31:0] ri;
    RST = 1'b0; InValid = 0; OutReady = 0; WE = 0; Wadr = 0; Wdata = 0; InIns = 0; InNextPC = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_outputs();
    chk("rst_in_ready", {31'b0, InReady}, 32'd1);
    RST = 1'b1;

    // Register setup and basic decode
    cyc(0, 0, 0, 1, 1, 5'd5, 32'h0000_0010);
    cyc(0, 0, 0, 1, 1, 5'd6, 32'hFFFF_FFF0);
    cyc(1, 32'h20A7_FFFC, 32'h0000_0104, 1, 0, 0, 0);
    chk("addi_r1", Rdata1, 32'h10);
    chk("addi_r2", Rdata2, 32'h0);
    chk("addi_ed", Ed32, 32'hFFFF_FFFC);
    cyc(1, 32'h3400_8001, 32'h0000_0108, 1, 0, 0, 0);
    chk("ori_ed", Ed32, 32'h0000_8001);
    cyc(1, 32'h3C00_1234, 32'h0000_010C, 1, 0, 0, 0);
    chk("lui_ed", Ed32, 32'h1234_0000);
    cyc(1, 32'h0006_0102, 32'h0000_0110, 1, 0, 0, 0);
    chk("srl_r1", Rdata1, 32'hFFFF_FFF0);
    chk("srl_r2", Rdata2, 32'd4);
    cyc(1, 32'h04A0_0000, 32'h0000_0114, 1, 0, 0, 0);
    chk("bltz_r2", Rdata2, 32'd1);
    cyc(1, 32'h04A1_0000, 32'h0000_0118, 1, 0, 0, 0);
    chk("bgez_r2", Rdata2, 32'd0);

    // Stall for three cycles, then release
    cyc(1, 32'h20A8_0001, 32'h0000_0200, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h20C9_0002, 32'h0000_0204, 0, (i == 1), 5'd7, 32'h7777_7777);
      chk("stall_ins", Ins, 32'h20A8_0001);
    end
    cyc(1, 32'h20C9_0002, 32'h0000_0204, 1, 0, 0, 0);
    chk("release_ins", Ins, 32'h20C9_0002);
    cyc(0, 0, 0, 1, 0, 0, 0);
    chk("drain_valid", {31'b0, OutValid}, 32'd0);

    // Same-cycle write and read of R[5], then discarded write to R[0]
    cyc(1, 32'h20A7_0000, 32'h0000_0300, 1, 1, 5'd5, 32'hDEAD_BEEF);
`ifdef ID_WB_BYPASS_EN
    chk("wb_same_cycle", Rdata1, 32'hDEAD_BEEF);
`else
    chk("wb_same_cycle", Rdata1, 32'h0000_0010);
`endif
    cyc(0, 0, 0, 1, 1, 5'd0, 32'hFFFF_FFFF);
    cyc(1, 32'h2000_0001, 32'h0000_0304, 1, 0, 0, 0);
    chk("r0_zero", Rdata1, 32'd0);

    // Reset asserted in the middle of a stall
    cyc(1, 32'h20A7_0000, 32'h0000_0400, 1, 0, 0, 0);
    cyc(1, 32'h20A7_0004, 32'h0000_0404, 0, 0, 0, 0);
    RST = 1'b0;
    #1;
    chk("rst_async_valid", {31'b0, OutValid}, 32'd0);
    chk("rst_async_r1", Rdata1, 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(1, 32'h20A7_0000, 32'h0000_0500, 1, 0, 0, 0);
    chk("post_rst_r5", Rdata1, 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      ri = $urandom;
      ri[31:26] = ops[$urandom_range(0, 9)];
      if (ri[31:26] == 6'h00) ri[5:0] = fns[$urandom_range(0, 7)];
      if (ri[31:26] == 6'h01) ri[20:16] = 5'($urandom_range(0, 1));
      cyc(($urandom_range(0, 3) != 0), ri, $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
